// File: rtl/sipo_deser_pkg.sv
// Shared definitions for the sipo_deser receive deserializer.
//   state_t      : framing FSM states (HUNT waits for frame_start, SHIFT collects bits)
//   count_width  : width of a counter able to hold the values 0..w
package sipo_deser_pkg;

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// One-entry holding register between the deserializer and the parallel consumer.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   load, word   : a completed word is offered this cycle
//   data_out     : held word
//   data_valid   : holding register is full
//   data_ready   : consumer accepts when data_valid is high
//   overrun      : sticky, set when a completed word had to be dropped
//   overrun_clr  : clears overrun (a simultaneous new overrun wins)
module sipo_hold_reg #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    input  logic             overrun_clr
);

    logic accept;
    logic drop;

    assign accept = data_valid & data_ready;
    // A word arriving while the register is full and not being read is lost.
    assign drop   = load & data_valid & ~data_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else if (load && !drop) begin
            data_out   <= word;
            data_valid <= 1'b1;
        end else if (accept) begin
            data_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out receive deserializer with frame realignment.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   serial_in    : serial bit, sampled when bit_valid is high
//   bit_valid    : qualifies serial_in
//   frame_start  : current valid bit is bit 0 of a word
//   data_out     : holding-register word
//   data_valid   : holding register full
//   data_ready   : consumer accepts
//   overrun      : sticky dropped-word flag
//   overrun_clr  : clears overrun
//   bit_count    : bits collected in the current partial word
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         serial_in,
    input  logic                         bit_valid,
    input  logic                         frame_start,
    output logic [WIDTH-1:0]             data_out,
    output logic                         data_valid,
    input  logic                         data_ready,
    output logic                         overrun,
    input  logic                         overrun_clr,
    output logic [$clog2(WIDTH+1)-1:0]   bit_count
);

    localparam int CW = count_width(int'(WIDTH));

    state_t           state, state_next;
    logic [CW-1:0]    count, count_next;
    logic [WIDTH-1:0] shreg, shreg_next, shifted;
    logic             word_done;

    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shreg[WIDTH-2:0], serial_in};
        end else begin
            shifted = {serial_in, shreg[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        shreg_next = shreg;
        word_done  = 1'b0;
        if (bit_valid) begin
            if (frame_start) begin
                // Stale partial bits need no clearing: they are shifted out
                // before the realigned word completes.
                state_next = SHIFT;
                count_next = CW'(1);
                shreg_next = shifted;
            end else if (state == SHIFT) begin
                shreg_next = shifted;
                if (count == CW'(WIDTH - 1)) begin
                    count_next = '0;
                    word_done  = 1'b1;
                end else begin
                    count_next = count + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HUNT;
            count <= '0;
            shreg <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            shreg <= shreg_next;
        end
    end

    assign bit_count = count;

    sipo_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (word_done),
        .word       (shreg_next),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

endmodule

// File: tb/tb_sipo_deser.sv
module tb_sipo_deser;

    localparam int W  = 16;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset, serial_in, bit_valid, frame_start, data_ready, overrun_clr;
    logic [W-1:0]  dout_m, dout_l;
    logic          dv_m, dv_l, ov_m, ov_l;
    logic [CW-1:0] bc_m, bc_l;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .data_out(dout_m), .data_valid(dv_m),
        .data_ready(data_ready), .overrun(ov_m), .overrun_clr(overrun_clr),
        .bit_count(bc_m)
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .data_out(dout_l), .data_valid(dv_l),
        .data_ready(data_ready), .overrun(ov_l), .overrun_clr(overrun_clr),
        .bit_count(bc_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: bits received since the last frame_start are kept in
    // time order; a word is formed from the list once it holds W bits.
    logic         bq[$];
    bit           in_frame;
    logic [W-1:0] m_do[2];
    bit           m_v[2];
    bit           m_ov[2];

    function automatic void model_edge(input logic r, v, s, f, rdy, clr);
        logic [W-1:0] w[2];
        bit complete, drop;
        if (r) begin
            bq.delete();
            in_frame = 0;
            for (int k = 0; k < 2; k++) begin
                m_do[k] = '0; m_v[k] = 0; m_ov[k] = 0;
            end
            return;
        end
        complete = 0;
        w[0] = '0; w[1] = '0;
        if (v) begin
            if (f) begin
                bq.delete();
                bq.push_back(s);
                in_frame = 1;
            end else if (in_frame) begin
                bq.push_back(s);
                if (bq.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        w[0][W-1-i] = bq[i];
                        w[1][i]     = bq[i];
                    end
                    bq.delete();
                    complete = 1;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            drop = 0;
            if (complete) begin
                if (!m_v[k] || rdy) begin
                    m_do[k] = w[k];
                    m_v[k]  = 1;
                end else begin
                    drop    = 1;
                    m_ov[k] = 1;
                end
            end else if (m_v[k] && rdy) begin
                m_v[k] = 0;
            end
            if (clr && !drop) m_ov[k] = 0;
        end
    endfunction

    task automatic cycle(input logic r, v, s, f, rdy, clr);
        reset = r; bit_valid = v; serial_in = s; frame_start = f;
        data_ready = rdy; overrun_clr = clr;
        @(posedge clk);
        model_edge(r, v, s, f, rdy, clr);
        #1;
        check("msb data_out",   32'(dout_m), 32'(m_do[0]));
        check("msb data_valid", 32'(dv_m),   32'(m_v[0]));
        check("msb overrun",    32'(ov_m),   32'(m_ov[0]));
        check("msb bit_count",  32'(bc_m),   32'(bq.size()));
        check("lsb data_out",   32'(dout_l), 32'(m_do[1]));
        check("lsb data_valid", 32'(dv_l),   32'(m_v[1]));
        check("lsb overrun",    32'(ov_l),   32'(m_ov[1]));
        check("lsb bit_count",  32'(bc_l),   32'(bq.size()));
    endtask

    // Sends w in time order w[W-1] first; optional idle cycle before each bit.
    task automatic send(input logic [W-1:0] w, input bit fs, input bit gapped,
                        input logic rdy, input int nbits);
        for (int i = W - 1; i >= W - nbits; i--) begin
            if (gapped) cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom), rdy, 1'b0);
            cycle(1'b0, 1'b1, w[i], fs && (i == W - 1), rdy, 1'b0);
        end
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; serial_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
        data_ready = 1'b0; overrun_clr = 1'b0;

        // Basic MSB-first word, and LSB-first on the second instance.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("reset data_valid", 32'(dv_m), 32'd0);
        check("reset bit_count",  32'(bc_m), 32'd0);
        send(16'b1000111000010110, 1'b1, 1'b0, 1'b1, W);
        check("basic msb word",  32'(dout_m), 32'h8E16);
        check("basic lsb word",  32'(dout_l), 32'h6871);
        check("basic valid",     32'(dv_m),   32'd1);
        check("basic overrun",   32'(ov_m),   32'd0);
        idle(1'b1);
        check("basic valid drop", 32'(dv_m), 32'd0);

        // Gapped bits with leading valid bits in HUNT.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int unsigned i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b1, 1'b0);
            idle(1'b1);
        end
        check("hunt bit_count", 32'(bc_m), 32'd0);
        send(16'h8E16, 1'b1, 1'b1, 1'b1, W);
        check("gapped word", 32'(dout_m), 32'h8E16);

        // Realign after 8 bits.
        send(16'h3C3C, 1'b1, 1'b0, 1'b1, 8);
        send(16'hA5A5, 1'b1, 1'b0, 1'b1, W);
        check("realign word",    32'(dout_m), 32'hA5A5);
        check("realign overrun", 32'(ov_m),   32'd0);
        idle(1'b1);

        // Backpressure and overrun.
        send(16'h1234, 1'b1, 1'b0, 1'b0, W);
        send(16'h5678, 1'b0, 1'b0, 1'b0, W);
        check("bp data_out", 32'(dout_m), 32'h1234);
        check("bp overrun",  32'(ov_m),   32'd1);
        idle(1'b1);
        check("bp read drops valid", 32'(dv_m), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("bp overrun_clr", 32'(ov_m), 32'd0);
        send(16'h1234, 1'b1, 1'b0, 1'b0, W);
        send(16'h5678, 1'b0, 1'b0, 1'b0, W - 1);
        send(16'h5678 << (W - 1), 1'b0, 1'b0, 1'b1, 1);
        check("bp ready on completion", 32'(dout_m), 32'h5678);
        check("bp no overrun",          32'(ov_m),   32'd0);

        // Reset mid-word with holding register full.
        send(16'hFFFF, 1'b1, 1'b0, 1'b0, 7);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("midreset data_out",  32'(dout_m), 32'd0);
        check("midreset valid",     32'(dv_m),   32'd0);
        check("midreset bit_count", 32'(bc_m),   32'd0);
        idle(1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("midreset hunt", 32'(bc_m), 32'd0);
        send(16'hC0DE, 1'b1, 1'b0, 1'b1, W);
        check("post reset word", 32'(dout_m), 32'hC0DE);

        // Randomized traffic.
        for (int unsigned n = 0; n < 3000; n++) begin
            cycle(1'($urandom_range(0, 199) == 0),
                  1'($urandom_range(0, 9) < 7),
                  1'($urandom),
                  1'($urandom_range(0, 19) == 0),
                  1'($urandom),
                  1'($urandom_range(0, 29) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
